// File: rtl/generador_cuadros_param_if.sv
// -----------------------------------------------------------------------------
// generador_cuadros_param_if
// Bundles the pixel stream, host write port, alarm request and the rendered
// outputs of the rectangle generator.
//   master : driven by the surrounding video/host logic (or a testbench)
//   slave  : the generator itself
// Signals:
//   video_on, pixel_x, pixel_y      pixel stream from the sync generator
//   wr_en, wr_idx, wr_field, wr_data shadow register-file write port
//   ring_on                          alarm request (level)
//   fig_RGB, graph_on, blink_phase   rendered colour, coverage flag, blink phase
// -----------------------------------------------------------------------------
interface generador_cuadros_param_if #(
  parameter int NUM_BOX = 4,
  parameter int COLOR_W = 12
);
  localparam int IDX_W = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1;

  logic               video_on;
  logic [9:0]         pixel_x;
  logic [9:0]         pixel_y;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [2:0]         wr_field;
  logic [COLOR_W-1:0] wr_data;
  logic               ring_on;
  logic [COLOR_W-1:0] fig_RGB;
  logic               graph_on;
  logic               blink_phase;

  modport master (
    output video_on, pixel_x, pixel_y, wr_en, wr_idx, wr_field, wr_data, ring_on,
    input  fig_RGB, graph_on, blink_phase
  );

  modport slave (
    input  video_on, pixel_x, pixel_y, wr_en, wr_idx, wr_field, wr_data, ring_on,
    output fig_RGB, graph_on, blink_phase
  );
endinterface

// File: rtl/generador_cuadros_param.sv
// -----------------------------------------------------------------------------
// generador_cuadros_param
// Draws NUM_BOX programmable rectangles over the 640x480 VGA picture, with
// optional blinking of selected boxes while the timer alarm rings. Host writes
// go to a shadow file that is copied to the active file once per frame, so a
// frame never shows a half-updated box. Output latency is one clock.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    generador_cuadros_param_if.slave (pixel stream, write port,
//          ring_on, fig_RGB / graph_on / blink_phase)
// Build option:
//   GEN_FIG_BORDER_EN  draw each box as a 2-pixel outline instead of filled
// -----------------------------------------------------------------------------
module generador_cuadros_param #(
  parameter int NUM_BOX      = 4,
  parameter int COLOR_W      = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  generador_cuadros_param_if.slave bus
);
  localparam int IDX_W = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1;
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [9:0]         xl;
    logic [9:0]         xr;
    logic [9:0]         yt;
    logic [9:0]         yb;
    logic [COLOR_W-1:0] color;
    logic               en;
    logic               blink;
  } box_t;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} blink_state_e;

  box_t               shadow_q [NUM_BOX];
  box_t               active_q [NUM_BOX];
  logic               origin_q;
  logic               frame_start;
  blink_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COLOR_W-1:0] rgb_q, color_d;
  logic               graph_q, any_d;
  logic               phase;
  logic               wr_ok;

  // One pulse per frame, even when (0,0) is held for several clocks by the
  // pixel-enable divider.
  assign frame_start = (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd0) && !origin_q;
  assign wr_ok       = bus.wr_en && ({1'b0, bus.wr_idx} < (IDX_W+1)'(NUM_BOX));

  always_ff @(posedge clk) begin
    if (!reset) origin_q <= 1'b0;
    else        origin_q <= (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd0);
  end

  // NOTE: the register files are reset so every box starts disabled; this is a
  // small flop array, not a RAM, so a reset costs nothing in inference.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BOX; i++) shadow_q[i] <= '0;
    end else if (wr_ok) begin
      case (bus.wr_field)
        3'd0: shadow_q[bus.wr_idx].xl    <= bus.wr_data[9:0];
        3'd1: shadow_q[bus.wr_idx].xr    <= bus.wr_data[9:0];
        3'd2: shadow_q[bus.wr_idx].yt    <= bus.wr_data[9:0];
        3'd3: shadow_q[bus.wr_idx].yb    <= bus.wr_data[9:0];
        3'd4: shadow_q[bus.wr_idx].color <= bus.wr_data;
        3'd5: begin
          shadow_q[bus.wr_idx].en    <= bus.wr_data[0];
          shadow_q[bus.wr_idx].blink <= bus.wr_data[1];
        end
        default: ;
      endcase
    end
  end

  // NOTE: non-blocking assignment means the commit copies the shadow value from
  // before any same-cycle write; that write waits for the next frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BOX; i++) active_q[i] <= '0;
    end else if (frame_start) begin
      active_q <= shadow_q;
    end
  end

  // Blink FSM: ON shows blink boxes, OFF hides them, swapping every
  // BLINK_FRAMES frame starts while the alarm rings.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.ring_on) state_d = S_ON;
      end
      S_ON, S_OFF: begin
        if (!bus.ring_on) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (frame_start) begin
          if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            state_d = (state_q == S_ON) ? S_OFF : S_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign phase = (state_q == S_ON);

  // Hit test and priority: scanning from the top index down lets the lowest
  // visible index overwrite the others.
  always_comb begin
    logic hit;
    color_d = '0;
    any_d   = 1'b0;
    for (int i = NUM_BOX - 1; i >= 0; i--) begin
      hit = active_q[i].en &&
            (active_q[i].xl <= bus.pixel_x) && (bus.pixel_x <= active_q[i].xr) &&
            (active_q[i].yt <= bus.pixel_y) && (bus.pixel_y <= active_q[i].yb);
`ifdef GEN_FIG_BORDER_EN
      // Boxes under 4 pixels in either direction stay filled.
      if (({1'b0, active_q[i].xr} - {1'b0, active_q[i].xl} >= 11'd3) &&
          ({1'b0, active_q[i].yb} - {1'b0, active_q[i].yt} >= 11'd3)) begin
        hit = hit && (({1'b0, bus.pixel_x} < {1'b0, active_q[i].xl} + 11'd2) ||
                      ({1'b0, bus.pixel_x} + 11'd2 > {1'b0, active_q[i].xr}) ||
                      ({1'b0, bus.pixel_y} < {1'b0, active_q[i].yt} + 11'd2) ||
                      ({1'b0, bus.pixel_y} + 11'd2 > {1'b0, active_q[i].yb}));
      end
`endif
      if (hit && (!active_q[i].blink || (bus.ring_on && phase))) begin
        color_d = active_q[i].color;
        any_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb_q   <= '0;
      graph_q <= 1'b0;
    end else begin
      rgb_q   <= bus.video_on ? color_d : '0;
      graph_q <= bus.video_on && any_d;
    end
  end

  assign bus.fig_RGB     = rgb_q;
  assign bus.graph_on    = graph_q;
  assign bus.blink_phase = phase;
endmodule

// File: tb/tb_generador_cuadros_param.sv
// -----------------------------------------------------------------------------
// tb_generador_cuadros_param
// Directed scenarios followed by random traffic. A frame-level reference model
// (box lists, frame counting since the alarm started) predicts each cycle's
// response; a monitor on the falling edge pops and compares it.
// -----------------------------------------------------------------------------
module tb_generador_cuadros_param;
  localparam int NB = 4;
  localparam int CW = 12;
  localparam int BF = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  generador_cuadros_param_if #(.NUM_BOX(NB), .COLOR_W(CW)) bus ();

  generador_cuadros_param #(.NUM_BOX(NB), .COLOR_W(CW), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int xl, xr, yt, yb, color;
    bit en, blink;
  } mbox_t;

  typedef struct {
    int rgb;
    bit g;
    bit ph;
  } exp_t;

  mbox_t sh [NB];
  mbox_t ac [NB];
  bit    ring_act;
  int    nfr;
  bit    prev_origin;

  exp_t  sb [$];
  string sb_tag [$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input mbox_t b, input int x, input int y);
    if (!b.en) return 1'b0;
    if (!(b.xl <= x && x <= b.xr && b.yt <= y && y <= b.yb)) return 1'b0;
`ifdef GEN_FIG_BORDER_EN
    if (b.xr - b.xl + 1 < 4 || b.yb - b.yt + 1 < 4) return 1'b1;
    return (x < b.xl + 2) || (x > b.xr - 2) || (y < b.yt + 2) || (y > b.yb - 2);
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit model_phase();
    return ring_act && ((nfr / BF) % 2 == 0);
  endfunction

  // Predict this cycle's response, advance the model, then let the edge happen.
  task automatic cyc(input string tag);
    exp_t e;
    int   x, y, col, d;
    bit   any, ph_now, origin, fs;
    x = int'(bus.pixel_x);
    y = int'(bus.pixel_y);
    e = '{0, 1'b0, 1'b0};
    if (!reset) begin
      for (int i = 0; i < NB; i++) begin
        sh[i] = '{0, 0, 0, 0, 0, 1'b0, 1'b0};
        ac[i] = '{0, 0, 0, 0, 0, 1'b0, 1'b0};
      end
      ring_act    = 1'b0;
      nfr         = 0;
      prev_origin = 1'b0;
    end else begin
      ph_now = model_phase();
      any    = 1'b0;
      col    = 0;
      for (int i = 0; i < NB; i++)
        if (!any && hit(ac[i], x, y) && (!ac[i].blink || (bus.ring_on && ph_now))) begin
          any = 1'b1;
          col = ac[i].color;
        end
      e.rgb = bus.video_on ? col : 0;
      e.g   = bus.video_on && any;
      origin      = (x == 0 && y == 0);
      fs          = origin && !prev_origin;
      prev_origin = origin;
      if (fs) ac = sh;
      if (bus.wr_en) begin
        d = int'(bus.wr_data);
        case (int'(bus.wr_field))
          0: sh[bus.wr_idx].xl    = d % 1024;
          1: sh[bus.wr_idx].xr    = d % 1024;
          2: sh[bus.wr_idx].yt    = d % 1024;
          3: sh[bus.wr_idx].yb    = d % 1024;
          4: sh[bus.wr_idx].color = d;
          5: begin
            sh[bus.wr_idx].en    = d[0];
            sh[bus.wr_idx].blink = d[1];
          end
          default: ;
        endcase
      end
      if (!bus.ring_on) begin
        ring_act = 1'b0;
        nfr      = 0;
      end else if (!ring_act) begin
        ring_act = 1'b1;
        nfr      = 0;
      end else if (fs) begin
        nfr++;
      end
      e.ph = model_phase();
    end
    @(posedge clk);
    sb.push_back(e);
    sb_tag.push_back(tag);
    #1;
  endtask

  // Monitor: outputs of cycle k are stable by the falling edge after edge k+1.
  always @(negedge clk) begin : monitor
    exp_t  e;
    string t;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      t = sb_tag.pop_front();
      check({t, " fig_RGB"}, 32'(bus.fig_RGB), 32'(e.rgb));
      check({t, " graph_on"}, 32'(bus.graph_on), 32'(e.g));
      check({t, " blink_phase"}, 32'(bus.blink_phase), 32'(e.ph));
    end
  end

  task automatic set_pix(input int x, input int y, input bit vo);
    bus.pixel_x  = 10'(x);
    bus.pixel_y  = 10'(y);
    bus.video_on = vo;
  endtask

  task automatic pix(input int x, input int y, input bit vo, input string tag);
    set_pix(x, y, vo);
    cyc(tag);
  endtask

  task automatic wr(input int idx, input int field, input int data);
    set_pix(1, 1, 1'b1);
    bus.wr_en    = 1'b1;
    bus.wr_idx   = 2'(idx);
    bus.wr_field = 3'(field);
    bus.wr_data  = 12'(data);
    cyc("write");
    bus.wr_en = 1'b0;
  endtask

  task automatic prog(input int idx, input int xl, input int xr, input int yt,
                      input int yb, input int col, input int attr);
    wr(idx, 0, xl);
    wr(idx, 1, xr);
    wr(idx, 2, yt);
    wr(idx, 3, yb);
    wr(idx, 4, col);
    wr(idx, 5, attr);
  endtask

  // Frame origin held for 1..3 clocks, as the pixel-enable divider does.
  task automatic frame();
    int hold;
    hold = 1 + int'($urandom_range(0, 2));
    for (int i = 0; i < hold; i++) pix(0, 0, 1'b1, "origin");
    pix(1, 0, 1'b1, "after_origin");
  endtask

  initial begin
    bus.video_on = 1'b0;
    bus.pixel_x  = '0;
    bus.pixel_y  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_idx   = '0;
    bus.wr_field = '0;
    bus.wr_data  = '0;
    bus.ring_on  = 1'b0;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) pix(200, 100, 1'b1, "reset");
    reset = 1'b1;

    // Basic hit and left edge.
    prog(0, 160, 479, 64, 255, 'h0AA, 1);
    frame();
    pix(160, 64, 1'b1, "box0_corner");
    pix(159, 64, 1'b1, "box0_left_outside");
    pix(479, 255, 1'b1, "box0_far_corner");
    pix(480, 255, 1'b1, "box0_right_outside");

    // Overlap priority.
    prog(0, 0, 99, 0, 99, 'hF00, 1);
    prog(1, 50, 149, 50, 149, 'h00F, 1);
    frame();
    pix(60, 60, 1'b1, "overlap_box0");
    pix(120, 120, 1'b1, "overlap_box1");

    // Commit only at frame start.
    prog(0, 160, 479, 64, 255, 'h0AA, 1);
    wr(1, 5, 0);
    frame();
    pix(200, 100, 1'b1, "commit_old");
    wr(0, 4, 'h0F0);
    pix(200, 100, 1'b1, "commit_still_old");
    frame();
    pix(200, 100, 1'b1, "commit_new");

    // Blink with the alarm ringing.
    prog(3, 544, 591, 64, 111, 'hF00, 3);
    frame();
    bus.ring_on = 1'b1;
    for (int f = 0; f < 6; f++) begin
      pix(560, 80, 1'b1, "blink_inside");
      pix(560, 80, 1'b1, "blink_inside");
      frame();
    end
    pix(560, 80, 1'b1, "blink_pre_drop");
    bus.ring_on = 1'b0;
    pix(560, 80, 1'b1, "ring_drop_1");
    pix(560, 80, 1'b1, "ring_drop_2");

    // Blanking and mid-frame reset.
    pix(200, 100, 1'b0, "video_off");
    pix(200, 100, 1'b1, "pre_reset");
    reset = 1'b0;
    pix(200, 100, 1'b1, "mid_reset");
    reset = 1'b1;
    frame();
    pix(200, 100, 1'b1, "after_reset");

    // Random traffic.
    for (int n = 0; n < 2500; n++) begin
      bus.wr_en = 1'b0;
      if (bus.pixel_x == 10'd0 && bus.pixel_y == 10'd0 && $urandom_range(0, 1) == 1) begin
        // keep the origin held
      end else if ($urandom_range(0, 99) < 5) begin
        set_pix(0, 0, 1'b1);
      end else begin
        set_pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                $urandom_range(0, 9) != 0);
      end
      if ($urandom_range(0, 99) < 15) begin
        bus.wr_en    = 1'b1;
        bus.wr_idx   = 2'($urandom_range(0, NB - 1));
        bus.wr_field = 3'($urandom_range(0, 7));
        bus.wr_data  = 12'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 49) == 0) bus.ring_on = ~bus.ring_on;
      reset = ($urandom_range(0, 299) != 0);
      cyc("random");
    end
    bus.wr_en = 1'b0;
    reset     = 1'b1;

    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/generador_cuadros_param.md
# generador_cuadros_param

Parametrised rectangle and alarm-figure generator for the 640x480 VGA clock display. It holds NUM_BOX runtime-programmable rectangles, each with its own coordinates, colour and attributes, and supports blinking of selected boxes for the timer "ring" alarm. Host writes are double-buffered and committed only at frame start, so a frame never shows a half-updated box. It sits between the VGA sync generator (pixel_x, pixel_y, video_on) and the final RGB mux, alongside the text generators.

## Interface
- NUM_BOX, 4: number of rectangles (1..16); index 0 has highest priority.
- COLOR_W, 12: RGB width (≥10, since coordinates share wr_data).
- BLINK_FRAMES, 30: frames per blink half-period (≥1).
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- video_on  in  1  visible-region flag from the sync generator.
- pixel_x, pixel_y  in  10 each  current pixel coordinates.
- wr_en  in  1  write strobe into the shadow register file.
- wr_idx  in  clog2(NUM_BOX) (min 1)  box index.
- wr_field  in  3  field select: 0 XL, 1 XR, 2 YT, 3 YB, 4 colour, 5 attributes (bit0 enable, bit1 blink).
- wr_data  in  COLOR_W  write data; coordinates use bits [9:0], attributes use bits [1:0].
- ring_on  in  1  alarm request, level-sensitive.
- fig_RGB  out  COLOR_W  registered pixel colour.
- graph_on  out  1  registered "some box covers this pixel".
- blink_phase  out  1  current blink phase (1 = blink boxes visible).

## Operation
- Shadow file: wr_en writes field wr_field of box wr_idx on the next edge. wr_idx ≥ NUM_BOX or wr_field 6..7 is ignored.
- Active file: the whole shadow file is copied to the active file on the cycle after frame_start. Rendering uses only the active file.
- frame_start: one-cycle pulse on the rising edge of the condition (pixel_x==0 && pixel_y==0). The condition holding for several clocks, as happens with the pixel-enable divider, gives exactly one pulse.
- A write in the same cycle as the commit lands in the shadow file and is committed at the next frame.
- Hit test for box i: enable && XL ≤ pixel_x ≤ XR && YT ≤ pixel_y ≤ YB, compared unsigned. XL > XR or YT > YB never hits.
- Visibility: a box with blink=0 is visible whenever it hits. A box with blink=1 is visible only when ring_on=1 and blink_phase=1.
- Priority: the lowest visible index supplies the colour. With no visible hit, the colour is 0.
- Blink FSM:
  - IDLE (ring_on=0): blink_phase=0, frame counter cleared.
  - ring_on rising: go to ON with blink_phase=1 and counter 0.
  - ON/OFF: the counter increments on each frame_start. When it reaches BLINK_FRAMES-1 and frame_start occurs, the phase toggles and the counter clears.
  - ring_on falling: return to IDLE on the next edge from any state.
- Output stage: if video_on=0, fig_RGB=0 and graph_on=0. Otherwise fig_RGB is the priority colour, and graph_on is the OR of visible hits.

## Timing
- Latency is exactly 1 clock: outputs at edge n+1 reflect pixel_x, pixel_y and video_on sampled at edge n. The sync generator delays hsync/vsync by one clock to match.
- Reset (reset=0 at an edge): fig_RGB=0, graph_on=0, blink_phase=0, FSM=IDLE, counter=0. All shadow and active fields are 0, so every box is disabled. The frame_start edge detector clears.
- Reset mid-frame takes effect at that edge. Rendering resumes disabled until boxes are rewritten and committed.
- Write-to-visible latency: the first frame_start after the write, plus 1 clock.
- A change in ring_on affects output at most 2 clocks later.

## Configuration
- GEN_FIG_BORDER_EN defined: each box is drawn as an outline only. A hit additionally requires pixel_x < XL+2, pixel_x > XR-2, pixel_y < YT+2 or pixel_y > YB-2, giving a 2-pixel border. Boxes narrower than 4 pixels are fully filled.
- Undefined: boxes are solid filled, matching the existing clock layout.

## Test plan
- Reset, then program box0 = (160,479,64,255), colour 0x0AA, enable, and wait one frame_start. Pixel (160,64) gives fig_RGB=0x0AA, graph_on=1 one clock later; pixel (159,64) gives 0/0.
- Overlap: box0 (0,99,0,99) colour 0xF00 and box1 (50,149,50,149) colour 0x00F. Pixel (60,60) gives 0xF00; pixel (120,120) gives 0x00F.
- Commit timing: rewrite box0 colour to 0x0F0 mid-frame. Old colour 0x0AA persists until frame_start, then 0x0F0 appears.
- Blink: box3 (544,591,64,111) colour 0xF00 with blink=1, BLINK_FRAMES=2, ring_on=1. The box is visible for frames 0-1, hidden for 2-3, visible for 4-5. Dropping ring_on hides it within 2 clocks and gives blink_phase=0.
- video_on=0 inside an enabled box gives fig_RGB=0, graph_on=0. Asserting reset mid-frame clears all outputs on the next edge.
- GEN_FIG_BORDER_EN build: box0 (160,479,64,255). Pixel (161,100) is on; pixel (300,100) is off.
